// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control-word types for the pipelined RV32I control path.
// The decoder, the pipeline registers and the forwarding unit all use these definitions.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Register indices a format does not use are carried as x0, so they never
    // match a destination in hazard or forwarding comparisons.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        alu_op_e    alu_ctrl;
        logic       alu_src;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rd;
    } mem_wb_t;

    localparam ctrl_t   CTRL_BUBBLE   = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    // Register and immediate ALU ops share one map; only the register form can subtract.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_5,
                                           input logic       allow_sub);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (allow_sub && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // The younger producer in MEM takes priority over the older one in WB.
    function automatic logic [1:0] forward_sel(input logic [4:0] rs,
                                               input logic       reg_write_m,
                                               input logic [4:0] rd_m,
                                               input logic       reg_write_w,
                                               input logic [4:0] rd_w);
        logic [1:0] sel;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: instruction word to control word, immediate
// format and illegal-opcode flag. Invalid or illegal slots decode to a bubble.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic [31:0] instr,
    input  logic        valid,
    output ctrl_t       ctrl,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    ctrl_t      word;
    logic       bad;
    logic       unused_imm_bits;

    assign opcode          = instr[6:0];
    assign rd              = instr[11:7];
    assign funct3          = instr[14:12];
    assign rs1             = instr[19:15];
    assign rs2             = instr[24:20];
    assign funct7_5        = instr[30];
    assign unused_imm_bits = ^{instr[31], instr[29:25]};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        word    = CTRL_BUBBLE;
        bad     = 1'b0;
        imm_src = IMM_I;
        case (opcode)
            OP_LOAD: begin
                word.reg_write  = 1'b1;
                word.result_src = RES_MEM;
                word.alu_ctrl   = ALU_ADD;
                word.alu_src    = 1'b1;
                word.funct3     = funct3;
                word.rd         = rd;
                word.rs1        = rs1;
            end
            OP_STORE: begin
                imm_src        = IMM_S;
                word.mem_write = 1'b1;
                word.alu_ctrl  = ALU_ADD;
                word.alu_src   = 1'b1;
                word.funct3    = funct3;
                word.rs1       = rs1;
                word.rs2       = rs2;
            end
            OP_REG: begin
                word.reg_write = 1'b1;
                word.alu_ctrl  = alu_decode(funct3, funct7_5, 1'b1);
                word.funct3    = funct3;
                word.rd        = rd;
                word.rs1       = rs1;
                word.rs2       = rs2;
            end
            OP_IMM: begin
                word.reg_write = 1'b1;
                word.alu_ctrl  = alu_decode(funct3, funct7_5, 1'b0);
                word.alu_src   = 1'b1;
                word.funct3    = funct3;
                word.rd        = rd;
                word.rs1       = rs1;
            end
            OP_BRANCH: begin
                imm_src     = IMM_B;
                word.branch = 1'b1;
                case (funct3)
                    3'b100, 3'b101: word.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: word.alu_ctrl = ALU_SLTU;
                    default:        word.alu_ctrl = ALU_SUB;
                endcase
                word.funct3 = funct3;
                word.rs1    = rs1;
                word.rs2    = rs2;
            end
            OP_JAL: begin
                if (EN_JUMP) begin
                    imm_src         = IMM_J;
                    word.jump       = 1'b1;
                    word.reg_write  = 1'b1;
                    word.result_src = RES_PC4;
                    word.rd         = rd;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_LUI: begin
                imm_src        = IMM_U;
                word.reg_write = 1'b1;
                word.alu_ctrl  = ALU_PASSB;
                word.alu_src   = 1'b1;
                word.rd        = rd;
            end
            default: bad = 1'b1;
        endcase

        illegal = valid && bad;
        ctrl    = (valid && !bad) ? word : CTRL_BUBBLE;
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control unit for the 5-stage RV32I core: ID decode, ID/EX, EX/MEM
// and MEM/WB control registers, load-use stall and EX operand forwarding.
module pipeline_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit EN_JUMP   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 hold,
    input  logic                 flush_e,
    output logic [2:0]           imm_src_d,
    output logic                 illegal_d,
    output logic                 stall_fd,
    output logic                 alu_src_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic [2:0]           funct3_e,
    output logic [4:0]           rd_e,
    output logic [4:0]           rs1_e,
    output logic [4:0]           rs2_e,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic                 mem_write_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [4:0]           rd_w
);

    ctrl_t   ctrl_d;
    ctrl_t   id_ex_q;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;
    logic    load_in_ex;
    logic    load_use;

    ctrl_decoder #(
        .EN_JUMP (EN_JUMP)
    ) u_decoder (
        .instr   (instr_d),
        .valid   (valid_d),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (illegal_d)
    );

    // Unused source fields decode as x0, so comparing against a nonzero rd is enough.
    assign load_in_ex = id_ex_q.reg_write && (id_ex_q.result_src == RES_MEM)
                        && (id_ex_q.rd != 5'd0);
    assign load_use   = load_in_ex
                        && ((ctrl_d.rs1 == id_ex_q.rd) || (ctrl_d.rs2 == id_ex_q.rd));

    // A flush redirects fetch, so holding IF/ID for the killed instruction is pointless.
    assign stall_fd = (load_use || hold) && !flush_e;

    // NOTE: pipeline state uses non-blocking assignments and clears asynchronously to a
    // bubble, so no stage can write a register or memory before real work arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= CTRL_BUBBLE;
        end else if (flush_e) begin
            id_ex_q <= CTRL_BUBBLE;
        end else if (hold) begin
            id_ex_q <= id_ex_q;
        end else if (load_use) begin
            id_ex_q <= CTRL_BUBBLE;
        end else begin
            id_ex_q <= ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem_q <= EX_MEM_BUBBLE;
        end else if (!hold) begin
            ex_mem_q <= '{reg_write:  id_ex_q.reg_write,
                          result_src: id_ex_q.result_src,
                          mem_write:  id_ex_q.mem_write,
                          rd:         id_ex_q.rd};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_q <= MEM_WB_BUBBLE;
        end else if (!hold) begin
            mem_wb_q <= '{reg_write:  ex_mem_q.reg_write,
                          result_src: ex_mem_q.result_src,
                          rd:         ex_mem_q.rd};
        end
    end

    assign forward_a_e = forward_sel(id_ex_q.rs1, ex_mem_q.reg_write, ex_mem_q.rd,
                                     mem_wb_q.reg_write, mem_wb_q.rd);
    assign forward_b_e = forward_sel(id_ex_q.rs2, ex_mem_q.reg_write, ex_mem_q.rd,
                                     mem_wb_q.reg_write, mem_wb_q.rd);

    assign alu_src_e    = id_ex_q.alu_src;
    assign branch_e     = id_ex_q.branch;
    assign jump_e       = id_ex_q.jump;
    assign alu_ctrl_e   = ALUCTRL_W'(id_ex_q.alu_ctrl);
    assign funct3_e     = id_ex_q.funct3;
    assign rd_e         = id_ex_q.rd;
    assign rs1_e        = id_ex_q.rs1;
    assign rs2_e        = id_ex_q.rs2;
    assign mem_write_m  = ex_mem_q.mem_write;
    assign reg_write_w  = mem_wb_q.reg_write;
    assign result_src_w = mem_wb_q.result_src;
    assign rd_w         = mem_wb_q.rd;

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Pipelined control unit for the 5-stage RV32I core. Decodes the instruction in ID, carries the control word through ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards and generates stall and forwarding selects. Supersedes the single-cycle control path. Extends it with a wider ALU operation set, jumps and LUI, pipeline hold/flush, and illegal-opcode reporting.

## Interface
Parameters:
- ALUCTRL_W, 4, ALU control width; encodings come from the package.
- EN_JUMP, 1, decode JAL (1101111); when 0, JAL is reported illegal.

Ports:
- clk  in  1  core clock; all registers rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_d  in  32  instruction in ID.
- valid_d  in  1  instr_d is a real instruction.
- hold  in  1  global freeze (memory wait).
- flush_e  in  1  taken branch/jump resolved in EX; kill ID/EX.
- imm_src_d  out  3  immediate format for ID: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_d  out  1  valid_d with unsupported opcode.
- stall_fd  out  1  freeze PC and IF/ID (load-use).
- alu_src_e, branch_e, jump_e  out  1 each  EX controls.
- alu_ctrl_e  out  ALUCTRL_W  ALU operation.
- funct3_e  out  3  branch condition select.
- rd_e, rs1_e, rs2_e  out  5 each  EX register indices.
- forward_a_e, forward_b_e  out  2  00 regfile, 10 from MEM, 01 from WB.
- mem_write_m  out  1  store enable.
- reg_write_w  out  1  register write enable.
- result_src_w  out  2  00 ALU, 01 memory, 10 PC+4.
- rd_w  out  5  writeback index.

## Operation
- Decode:
  - lw: I-type, ADD, rs_src imm, result 01, reg_write.
  - sw: S-type, ADD, mem_write.
  - R-type: funct3/funct7[5] → ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - I-ALU: same map except SUB never produced; SRAI selected by funct7[5].
  - branch: B-type, branch=1; beq/bne → SUB, blt/bge → SLT, bltu/bgeu → SLTU.
  - JAL: J-type, jump=1, result 10, reg_write.
  - LUI: U-type, PASSB, alu_src=1, reg_write.
- Illegal or !valid_d: control word is a bubble (reg_write, mem_write, branch, jump = 0).
- Load-use hazard:
  - Condition: ID/EX holds a load, rd_e≠0, and rd_e equals rs1_d or rs2_d, where that source is used by the ID instruction. rs2 is unused for I/U/J types.
  - Response: stall_fd=1 and a bubble enters ID/EX. EX/MEM and MEM/WB advance.
- Forwarding (combinational on EX registers): forward_a_e=10 if reg_write_m && rd_m≠0 && rd_m==rs1_e; else 01 if reg_write_w && rd_w≠0 && rd_w==rs1_e; else 00. forward_b_e is the same rule using rs2_e. The MEM match wins.
- Precedence per cycle:
  - ID/EX: flush_e > hold > load-use bubble > load.
  - EX/MEM and MEM/WB: hold > load.
- stall_fd is 1 when there is a load-use hazard or hold, and is 0 when flush_e.

## Timing
- Control for an instruction sampled in ID appears on *_e after 1 edge, *_m after 2, *_w after 3.
- imm_src_d, illegal_d, stall_fd and forward_* are combinational. No other output is combinational.
- Reset (rst low, asynchronous): every pipeline register clears to bubble. All outputs read 0: rd/rs fields 0, alu_ctrl_e ADD (0), forward 00, stall_fd 0.
- Reset released mid-operation: the first edge after release loads ID normally.
- Load-use stall lasts exactly one cycle. In the following cycle the load is in MEM, and the dependency is forwarded from WB one cycle later.
- flush_e together with a load-use hazard: bubble, stall_fd=0.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALU encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10;
  - imm_src and result_src encodings;
  - the packed control-word typedef.
- Sub-module ctrl_decoder: purely combinational instr → control word and illegal flag.
- The top contains the three pipeline registers, hazard logic and forwarding.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3), valid: alu_ctrl_e=0 and rd_e=3 after 1 edge; reg_write_w=1, rd_w=3, result_src_w=00 after 3 edges.
- `lw x5,0(x1)` followed by `add x6,x5,x7`: stall_fd=1 for exactly one cycle with the add in ID, a bubble in EX, then forward_a_e=01 when the add reaches EX.
- `addi x4,x0,1` then `sub x8,x4,x4`: forward_a_e=forward_b_e=10. With rd=x0 instead: both 00.
- `beq` in EX with flush_e=1 on the same cycle a load-use exists: next EX is a bubble, stall_fd=0, mem_write_m stays 0.
- Opcode 0x7F valid: illegal_d=1, no write downstream. EN_JUMP=0 with JAL: illegal_d=1.
- hold=1 for 3 cycles mid-stream: all *_e/_m/_w outputs frozen. rst asserted mid-stream clears every output immediately, without waiting for a clock edge.
